// File: rtl/dctq_frame_feeder.sv
// rtl/dctq_frame_feeder.sv - frame-memory to DCTQ block feeder with completion counting.
// Optional FEEDER_STALL_EN adds a stall input, drives hold and keeps a one-word read skid register.
module dctq_frame_feeder #(
    parameter int NUM_BLKS = 1024,
    parameter int ADDR_W   = 13,
    parameter int CNT_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    output logic [63:0]       di,
    output logic              din_valid,
    output logic [2:0]        wa,
    output logic [7:0]        be,
    input  logic              ready,
    output logic              start,
    output logic              hold,
    input  logic              dctq_valid,
    input  logic [5:0]        addr,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_sent,
    output logic [CNT_W-1:0]  blk_done,
`ifdef FEEDER_STALL_EN
    input  logic              stall,
`endif
    output logic              frame_done
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_RDY, DRAIN} state_t;

    localparam logic [CNT_W-1:0] NB_C = CNT_W'(NUM_BLKS);

    state_t             state;
    logic [3:0]         lcnt;
    logic               mem_rd_q;
    logic               din_valid_q;
    logic               start_q;
    logic               frame_done_q;
    logic               eob;
    logic               frz;
    logic [63:0]        row_data;
    logic [CNT_W-1:0]   sent_nxt;

    assign sent_nxt = blk_sent + 1'b1;

`ifdef FEEDER_STALL_EN
    logic        rd_prev;
    logic        skid_valid;
    logic [63:0] skid;

    assign frz  = stall;
    assign hold = stall;

    // A word whose read was issued just before the stall lands in the first
    // stall cycle; it is parked here and replayed on the first free cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_prev    <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
        end else begin
            rd_prev <= mem_rd;
            if (stall) begin
                if (rd_prev) begin
                    skid       <= mem_rdata;
                    skid_valid <= 1'b1;
                end
            end else begin
                skid_valid <= 1'b0;
            end
        end
    end

    assign row_data = skid_valid ? skid : mem_rdata;
`else
    assign frz      = 1'b0;
    assign hold     = 1'b0;
    assign row_data = mem_rdata;
`endif

    assign mem_rd     = mem_rd_q & ~frz;
    assign din_valid  = din_valid_q & ~frz;
    assign start      = start_q & ~frz;
    assign frame_done = frame_done_q & ~frz;
    assign be         = din_valid ? 8'h00 : 8'hFF;
    assign di         = din_valid ? row_data : 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lcnt         <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr     <= '0;
            din_valid_q  <= 1'b0;
            wa           <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy         <= 1'b0;
            blk_sent     <= '0;
        end else if (!frz) begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        mem_addr <= '0;
                        blk_sent <= '0;
                        busy     <= 1'b1;
                        lcnt     <= '0;
                        mem_rd_q <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Reads go out in cycles 0..7; each word is shown one cycle later.
                    lcnt <= lcnt + 1'b1;
                    if (lcnt <= 4'd7) begin
                        mem_addr    <= mem_addr + 1'b1;
                        mem_rd_q    <= (lcnt != 4'd7);
                        din_valid_q <= 1'b1;
                        wa          <= lcnt[2:0];
                    end else begin
                        din_valid_q <= 1'b0;
                        state       <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        start_q  <= 1'b1;
                        blk_sent <= sent_nxt;
                        if (sent_nxt < NB_C) begin
                            lcnt     <= '0;
                            mem_rd_q <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (blk_done == NB_C) begin
                        frame_done_q <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completions keep counting through a stall; they are ignored outside a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eob      <= 1'b0;
            blk_done <= '0;
        end else begin
            eob <= dctq_valid && (addr == 6'd63);
            if (state == IDLE && frame_start && !frz)
                blk_done <= '0;
            else if (busy && eob)
                blk_done <= blk_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_dctq_frame_feeder.sv
// tb/tb_dctq_frame_feeder.sv - randomized self-checking bench for dctq_frame_feeder.
module tb_dctq_frame_feeder;

    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        mem_rd;
    logic [12:0] mem_addr;
    logic [63:0] mem_rdata;
    logic [63:0] di;
    logic        din_valid;
    logic [2:0]  wa;
    logic [7:0]  be;
    logic        ready;
    logic        start;
    logic        hold;
    logic        dctq_valid;
    logic [5:0]  addr;
    logic        busy;
    logic [10:0] blk_sent;
    logic [10:0] blk_done;
    logic        frame_done;
`ifdef FEEDER_STALL_EN
    logic        stall = 1'b0;
`endif

    dctq_frame_feeder #(.NUM_BLKS(NB), .ADDR_W(13), .CNT_W(11)) dut (
        .clk(clk), .reset(rst), .frame_start(frame_start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .di(di), .din_valid(din_valid), .wa(wa), .be(be),
        .ready(ready), .start(start), .hold(hold),
        .dctq_valid(dctq_valid), .addr(addr),
        .busy(busy), .blk_sent(blk_sent), .blk_done(blk_done),
`ifdef FEEDER_STALL_EN
        .stall(stall),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:8191];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : {$urandom, $urandom};

    int n_chk = 0;
    int n_err = 0;

    logic [66:0] rows[$];
    logic [12:0] rds[$];
    int          starts[$];
    int          bdseq[$];
    int          fd_cnt, be_bad, hold_cnt, busy_rise;
    logic        fd_busy, busy_d;
    logic [10:0] bd_d;

    initial begin
        busy_d = 1'b0; bd_d = '0; busy_rise = 0;
        forever begin
            @(negedge clk);
            if (din_valid) begin
                rows.push_back({wa, di});
                if (be !== 8'h00) be_bad++;
            end
            if (mem_rd) rds.push_back(mem_addr);
            if (start) starts.push_back(cyc);
            if (hold) hold_cnt++;
            if (busy && !busy_d) busy_rise = cyc;
            if (frame_done) begin fd_cnt++; fd_busy = busy; end
            if (blk_done != bd_d && blk_done != 0) bdseq.push_back(int'(blk_done));
            busy_d = busy;
            bd_d   = blk_done;
        end
    end

    int dq_pend, dq_beat;
    initial begin
        dctq_valid = 1'b0; addr = '0; dq_pend = 0; dq_beat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dq_pend = 0; dq_beat = 0; dctq_valid = 1'b0;
            end else begin
                if (start) dq_pend++;
                if ((dq_beat > 0 || dq_pend > 0) && $urandom_range(0, 3) != 0) begin
                    if (dq_beat == 0) dq_pend--;
                    dctq_valid = 1'b1;
                    addr       = 6'(dq_beat);
                    dq_beat    = (dq_beat + 1) % 64;
                end else begin
                    dctq_valid = 1'b0;
                    addr       = 6'($urandom);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] exp_row(input int i);
        logic [2:0] r;
        r = 3'(i % 8);
        return {r, mem[i]};
    endfunction

    task automatic clear_logs();
        rows.delete(); rds.delete(); starts.delete(); bdseq.delete();
        fd_cnt = 0; be_bad = 0; hold_cnt = 0; fd_busy = 1'b1;
    endtask

    task automatic pulse_fs();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (fd_cnt == 0 && n < limit) begin @(negedge clk); n++; end
        chk({tag, "_done_timeout"}, fd_cnt > 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_di"}, di, 0);
        chk({tag, "_din_valid"}, din_valid, 0);
        chk({tag, "_wa"}, wa, 0);
        chk({tag, "_be"}, be, 8'hFF);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_hold"}, hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_blk_sent"}, blk_sent, 0);
        chk({tag, "_blk_done"}, blk_done, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // A whole frame is the words 0..NB*8-1 in order, each row tagged with its index in the block.
    task automatic check_frame(input string tag);
        chk({tag, "_row_count"}, rows.size(), NB * 8);
        for (int i = 0; i < rows.size() && i < NB * 8; i++) chk({tag, "_row"}, rows[i], exp_row(i));
        chk({tag, "_rd_count"}, rds.size(), NB * 8);
        for (int i = 0; i < rds.size() && i < NB * 8; i++) chk({tag, "_rd_addr"}, rds[i], 13'(i));
        chk({tag, "_done_seq_len"}, bdseq.size(), NB);
        for (int i = 0; i < bdseq.size() && i < NB; i++) chk({tag, "_done_seq"}, bdseq[i], i + 1);
        chk({tag, "_starts"}, starts.size(), NB);
        chk({tag, "_fd_count"}, fd_cnt, 1);
        chk({tag, "_busy_at_fd"}, fd_busy, 0);
        chk({tag, "_be"}, be_bad, 0);
        chk({tag, "_blk_sent"}, blk_sent, NB);
        chk({tag, "_blk_done"}, blk_done, NB);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
        rst = 1'b1; frame_start = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: ready always high, starts 10 cycles apart.
        ready = 1'b1;
        clear_logs();
        pulse_fs();
        wait_done("f1", 2000);
        check_frame("f1");
        chk("f1_hold", hold_cnt, 0);
        for (int i = 0; i < starts.size() && i < NB; i++)
            chk("f1_start_delay", starts[i] - busy_rise, 10 * (i + 1));

        // Frame 2: ready low for 50 cycles, plus a frame_start while busy.
        ready = 1'b0;
        clear_logs();
        pulse_fs();
        repeat (20) @(negedge clk);
        pulse_fs();
        repeat (28) @(negedge clk);
        chk("f2_no_start", starts.size(), 0);
        chk("f2_rd_first_blk", rds.size(), 8);
        chk("f2_rows_first_blk", rows.size(), 8);
        chk("f2_mem_addr", mem_addr, 8);
        chk("f2_din_valid_idle", din_valid, 0);
        chk("f2_blk_sent", blk_sent, 0);
        k = cyc;
        ready = 1'b1;
        wait_done("f2", 2000);
        check_frame("f2");
        if (starts.size() > 0) chk("f2_start_on_ready", starts[0], k + 1);

        // Frame 3: ready toggles at random.
        clear_logs();
        pulse_fs();
        n = 0;
        while (fd_cnt == 0 && n < 3000) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("f3_done_timeout", fd_cnt > 0, 1);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check_frame("f3");

        // Reset in the middle of block 1 row 4.
        clear_logs();
        pulse_fs();
        n = 0;
        while (!(mem_rd && mem_addr == 13'd12) && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_reach", n < 200, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        clear_logs();
        repeat (40) @(negedge clk);
        chk("rst_mid_no_start", starts.size(), 0);
        chk("rst_mid_no_rd", rds.size(), 0);
        chk("rst_mid_busy", busy, 0);

`ifdef FEEDER_STALL_EN
        // Stall in LOAD cycles 4..6 of block 0.
        clear_logs();
        pulse_fs();
        repeat (4) @(posedge clk);
        #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        wait_done("stall", 2000);
        check_frame("stall");
        chk("stall_hold_cycles", hold_cnt, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dctq_frame_feeder.md
Name: dctq_frame_feeder

Overview:
- Initiator for the DCTQ core's input port. Reads a frame of 8x8 pixel blocks from a 64-bit-wide frame memory, one row per word.
- Writes each block row-by-row into DCTQ over di/wa/be/din_valid, waits for ready, then pulses start.
- Counts end-of-block events on the DCTQ output side and flags frame completion.
- Replaces the behavioural block loader used in simulation with synthesizable RTL.

Parameters:
NUM_BLKS, 1024, blocks per frame (256x256 image)
ADDR_W, 13, frame memory word address width (NUM_BLKS*8 words)
CNT_W, 11, width of block counters (must hold NUM_BLKS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
frame_start  in  1  one-cycle pulse; begins a frame; ignored while busy
mem_rd  out  1  frame memory read enable
mem_addr  out  ADDR_W  frame memory word address
mem_rdata  in  64  read data, valid exactly 1 cycle after mem_rd
di  out  64  row data to DCTQ
din_valid  out  1  di/wa valid
wa  out  3  row index within block, 0..7
be  out  8  byte enables, active-low; always 8'h00 while din_valid=1
ready  in  1  DCTQ can accept start
start  out  1  one-cycle pulse; block loaded
hold  out  1  DCTQ hold; tied 0 unless FEEDER_STALL_EN
dctq_valid  in  1  DCTQ coefficient valid
addr  in  6  DCTQ coefficient index
busy  out  1  frame in progress
blk_sent  out  CNT_W  blocks started this frame
blk_done  out  CNT_W  blocks completed this frame
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, di=0, din_valid=0, wa=0, be=8'hFF, start=0, hold=0, busy=0, blk_sent=0, blk_done=0, frame_done=0; FSM=IDLE.
- Reset mid-frame aborts the frame. No start is issued after reset deasserts until a new frame_start.
- FSM states:
  - IDLE: on frame_start, clear mem_addr/blk_sent/blk_done, busy<=1, go to LOAD.
  - LOAD: 9 cycles. Cycles 0..7 assert mem_rd with mem_addr = block*8+row, address incrementing each cycle. Cycles 1..8 assert din_valid, di=mem_rdata, wa=row-1 (wa 0..7 in order), be=8'h00. Then go to WAIT_RDY.
  - WAIT_RDY: when ready=1, assert start for exactly 1 cycle and increment blk_sent. If blk_sent (new value) < NUM_BLKS, go to LOAD; else go to DRAIN.
  - DRAIN: wait until blk_done == NUM_BLKS, then pulse frame_done 1 cycle, busy<=0, go to IDLE.
- ready is sampled only in WAIT_RDY. A ready that is high at the end of LOAD yields start on the first WAIT_RDY cycle, i.e. 10 cycles after entering LOAD.
- Completion counter: eob is a registered (dctq_valid && addr==63). blk_done increments on eob in any state while busy; eob is ignored in IDLE.
- frame_done occurs 1 cycle after the final blk_done increment, at the earliest.
- mem_addr wraps naturally at 2^ADDR_W; with default parameters the last word read is 8191.
- frame_start while busy has no effect.

Optional Feature:
FEEDER_STALL_EN:
- When defined, adds input stall (1 bit).
- While stall=1: FSM frozen, mem_rd=0, din_valid=0, start=0, hold=1.
- Read data arriving during the stall cycle is captured in a 64-bit skid register and presented (with its wa) on the first cycle after stall falls. No row is lost or duplicated.
- blk_done continues counting during stall.
- When not defined: no stall port, hold tied 0, no skid register.

Test Plan:
- Reset, then frame_start with NUM_BLKS=2, ready=1 constantly -> mem_addr 0..7 then 8..15. wa sequence 0..7 twice with be=8'h00. start pulses 10 and 20 cycles after frame_start is accepted. blk_sent=2.
- ready held low 50 cycles after first LOAD -> din_valid stays 0, no mem_rd, start=0 until ready rises; start appears the cycle ready is sampled high.
- Model DCTQ emitting addr 0..63 with dctq_valid after each start, NUM_BLKS=2 -> blk_done 1 then 2; frame_done pulses once; busy falls same cycle; second frame_start works and reads from mem_addr 0.
- Assert reset during row 4 of block 1 -> all outputs at reset values next cycle; no start afterwards without frame_start.
- frame_start pulsed while busy -> counters and mem_addr unaffected.
- With FEEDER_STALL_EN, stall=1 for 3 cycles at LOAD cycle 4 -> hold=1 for those 3 cycles; di/wa stream resumes exactly at wa=3; memory words 0..7 delivered each once, in order.
